// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud calibration controller: times a host 0x55 sync byte on the raw RX line,
// programs the receiver's clocks-per-bit, then confirms lock with a second 0x55 through the receiver.
module uart_autobaud_ctrl #(
  parameter logic [11:0] CPB_DEFAULT = 12'd104,
  parameter logic [11:0] CPB_MIN     = 12'd8,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1000000
) (
  input  logic        i_Clock,
  input  logic        i_Rst_L,
  input  logic        i_RX_Serial_asyn,
  input  logic        i_Calib_Start,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic [11:0] o_Clk_per_bit,
  output logic        o_Rx_Rst_H,
  output logic        o_Busy,
  output logic        o_Locked,
  output logic        o_Error
);

  localparam int unsigned CPB_W  = 12;
  localparam int unsigned MEAS_W = 15;
  localparam int unsigned EDGE_W = 3;
  localparam int unsigned TMO_W  = 24;
  localparam int unsigned RND_W  = 16;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_MEASURE,
    S_SETTLE,
    S_VERIFY,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic                rx_meta_q, rx_sync_q, rx_prev_q;
  logic [MEAS_W-1:0]   meas_cnt_q, meas_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [CPB_W-1:0]    cpb_q, cpb_d;
  logic [CPB_W-1:0]    shadow_q, shadow_d;
  logic                rx_rst_q, rx_rst_d;
  logic                busy_q, busy_d;
  logic                locked_q, locked_d;
  logic                error_q, error_d;

  logic                fall_c, rise_c, tmo_hit_c;
  logic [RND_W-1:0]    meas_rnd_c;
  logic [CPB_W:0]      cpb_wide_c;
  logic [CPB_W-1:0]    cpb_calc_c;

  // RX synchronizer plus one delay stage for edge detection; idles high
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_RX_Serial_asyn;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall_c    = rx_prev_q & ~rx_sync_q;
  assign rise_c    = ~rx_prev_q & rx_sync_q;
  assign tmo_hit_c = (tmo_cnt_q == (TIMEOUT_CYC - TMO_W'(1)));

  // Eight bit-times measured: round to nearest, saturate rather than wrap
  assign meas_rnd_c = RND_W'(meas_cnt_q) + RND_W'(4);
  assign cpb_wide_c = (CPB_W+1)'(meas_rnd_c >> 3);
  assign cpb_calc_c = cpb_wide_c[CPB_W] ? {CPB_W{1'b1}} : cpb_wide_c[CPB_W-1:0];

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      meas_cnt_q <= '0;
      edge_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      cpb_q      <= CPB_DEFAULT;
      shadow_q   <= CPB_DEFAULT;
      rx_rst_q   <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      meas_cnt_q <= meas_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      cpb_q      <= cpb_d;
      shadow_q   <= shadow_d;
      rx_rst_q   <= rx_rst_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    meas_cnt_d = meas_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    cpb_d      = cpb_q;
    shadow_d   = shadow_q;
    rx_rst_d   = rx_rst_q;
    busy_d     = busy_q;
    locked_d   = locked_q;
    error_d    = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_Calib_Start) begin
          state_d   = S_WAIT_EDGE;
          shadow_d  = cpb_q;
          locked_d  = 1'b0;
          error_d   = 1'b0;
          rx_rst_d  = 1'b1;
          busy_d    = 1'b1;
          tmo_cnt_d = '0;
        end
      end

      S_WAIT_EDGE: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (fall_c) begin
          state_d    = S_MEASURE;
          meas_cnt_d = '0;
          edge_cnt_d = EDGE_W'(1);
          tmo_cnt_d  = '0;
        end else if (tmo_hit_c) begin
          state_d = S_ERROR;
        end
      end

      S_MEASURE: begin
        meas_cnt_d = meas_cnt_q + MEAS_W'(1);
        tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
        if (fall_c) begin
          edge_cnt_d = edge_cnt_q + EDGE_W'(1);
        end
        if (fall_c && (edge_cnt_q == LAST_EDGE)) begin
          if (cpb_calc_c < CPB_MIN) begin
            state_d = S_ERROR;
          end else begin
            cpb_d     = cpb_calc_c;
            state_d   = S_SETTLE;
            tmo_cnt_d = '0;
          end
        end else if ((meas_cnt_q == {MEAS_W{1'b1}}) || tmo_hit_c) begin
          state_d = S_ERROR;
        end
      end

      // Release the receiver once the sync byte's stop bit begins
      S_SETTLE: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (rise_c) begin
          rx_rst_d  = 1'b0;
          state_d   = S_VERIFY;
          tmo_cnt_d = '0;
        end else if (tmo_hit_c) begin
          state_d = S_ERROR;
        end
      end

      S_VERIFY: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (i_RX_DV) begin
          if (i_RX_Byte == 8'h55) begin
            locked_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d = S_ERROR;
          end
        end else if (tmo_hit_c) begin
          state_d = S_ERROR;
        end
      end

      S_ERROR: begin
        cpb_d    = shadow_q;
        error_d  = 1'b1;
        rx_rst_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_Clk_per_bit = cpb_q;
  assign o_Rx_Rst_H    = rx_rst_q;
  assign o_Busy        = busy_q;
  assign o_Locked      = locked_q;
  assign o_Error       = error_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl: sync-byte measurement, verify, error, timeout and reset paths.
module tb_uart_autobaud_ctrl;

  localparam logic [23:0] TMO = 24'd5000;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        start;
  logic        dv;
  logic [7:0]  rx_byte;
  logic [11:0] cpb;
  logic        rx_rst_h;
  logic        busy;
  logic        locked;
  logic        error;

  int n_checks;
  int n_fail;

  uart_autobaud_ctrl #(
    .CPB_DEFAULT (12'd104),
    .CPB_MIN     (12'd8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_Clock          (clk),
    .i_Rst_L          (rst_n),
    .i_RX_Serial_asyn (rx),
    .i_Calib_Start    (start),
    .i_RX_DV          (dv),
    .i_RX_Byte        (rx_byte),
    .o_Clk_per_bit    (cpb),
    .o_Rx_Rst_H       (rx_rst_h),
    .o_Busy           (busy),
    .o_Locked         (locked),
    .o_Error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_dv(input logic [7:0] b);
    @(negedge clk);
    dv      = 1'b1;
    rx_byte = b;
    @(negedge clk);
    dv      = 1'b0;
  endtask

  // Drives the first nbits of a 10-bit frame; optionally pulses start during frame bit 3
  task automatic send_frame(input logic [7:0] b, input int cpb_n, input int nbits, input bit inj);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < cpb_n; c++) begin
        @(negedge clk);
        rx    = frame[i];
        start = inj && (i == 3) && (c == 0);
      end
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    start    = 1'b0;
    dv       = 1'b0;
    rx_byte  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset values
    check("rst_cpb", 32'(cpb), 32'd104);
    check("rst_rxrst", 32'(rx_rst_h), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_error", 32'(error), 32'd0);

    // 2: successful lock at 100 clk/bit
    pulse_start();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_rxrst_hi", 32'(rx_rst_h), 32'd1);
    send_frame(8'h55, 100, 10, 1'b0);
    check("t2_cpb", 32'(cpb), 32'd100);
    check("t2_rxrst_lo", 32'(rx_rst_h), 32'd0);
    check("t2_locked_pre", 32'(locked), 32'd0);
    pulse_dv(8'h55);
    check("t2_locked", 32'(locked), 32'd1);
    check("t2_busy_lo", 32'(busy), 32'd0);
    check("t2_error", 32'(error), 32'd0);
    pulse_dv(8'h00);
    @(negedge clk);
    check("t2_dv_idle_err", 32'(error), 32'd0);
    check("t2_dv_idle_lock", 32'(locked), 32'd1);

    // 3: wrong verify byte restores the pre-calibration value
    do_reset();
    pulse_start();
    send_frame(8'h55, 100, 10, 1'b0);
    check("t3_cpb_meas", 32'(cpb), 32'd100);
    pulse_dv(8'h00);
    repeat (2) @(negedge clk);
    check("t3_error", 32'(error), 32'd1);
    check("t3_cpb", 32'(cpb), 32'd104);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_locked", 32'(locked), 32'd0);

    // 4: measured rate below the minimum
    pulse_start();
    check("t4_err_clr", 32'(error), 32'd0);
    send_frame(8'h55, 5, 10, 1'b0);
    repeat (5) @(negedge clk);
    check("t4_error", 32'(error), 32'd1);
    check("t4_cpb", 32'(cpb), 32'd104);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_rxrst", 32'(rx_rst_h), 32'd0);

    // 5: idle line times out
    pulse_start();
    repeat (4900) @(negedge clk);
    check("t5_busy_pre", 32'(busy), 32'd1);
    check("t5_err_pre", 32'(error), 32'd0);
    repeat (200) @(negedge clk);
    check("t5_error", 32'(error), 32'd1);
    check("t5_rxrst", 32'(rx_rst_h), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cpb", 32'(cpb), 32'd104);

    // 6: start pulse mid-measure is ignored, then async reset mid-measure
    do_reset();
    pulse_start();
    send_frame(8'h55, 100, 10, 1'b1);
    check("t6_cpb", 32'(cpb), 32'd100);
    check("t6_busy", 32'(busy), 32'd1);
    pulse_dv(8'h55);
    check("t6_locked", 32'(locked), 32'd1);
    pulse_start();
    send_frame(8'h55, 100, 4, 1'b0);
    check("t6_busy_mid", 32'(busy), 32'd1);
    check("t6_rxrst_mid", 32'(rx_rst_h), 32'd1);
    @(negedge clk);
    rx    = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_cpb", 32'(cpb), 32'd104);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_locked", 32'(locked), 32'd0);
    check("t6_rst_error", 32'(error), 32'd0);
    check("t6_rst_rxrst", 32'(rx_rst_h), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
